// File: rtl/oled_spi_sink_if.sv
// OLED SPI pin bundle: the controller drives it (master), the panel model samples it (slave).
interface oled_spi_sink_if;
    logic CS;
    logic SDIN;
    logic SCLK;
    logic DC;

    modport master (output CS, output SDIN, output SCLK, output DC);
    modport slave  (input  CS, input  SDIN, input  SCLK, input  DC);
endinterface

// File: rtl/oled_spi_sink.sv
// SSD1306-subset panel model: oversamples the OLED SPI pins, assembles bytes, decodes
// addressing commands and stores data bytes into a page/column frame buffer.
module oled_spi_sink #(
    parameter int SYNC_STAGES = 2,
    parameter int NUM_PAGES   = 4,
    parameter int NUM_COLS    = 128
) (
    input  logic                                           clk,
    input  logic                                           reset,
    oled_spi_sink_if.slave                                 spi,
    output logic                                           byte_valid,
    output logic [7:0]                                     byte_data,
    output logic                                           byte_is_data,
    output logic                                           display_on,
    output logic                                           frame_done,
    output logic [7:0]                                     cmd_count,
    output logic                                           proto_err,
    input  logic [$clog2(NUM_PAGES)+$clog2(NUM_COLS)-1:0]  rd_addr,
    output logic [7:0]                                     rd_data
);
    localparam int PW  = $clog2(NUM_PAGES);
    localparam int CW  = $clog2(NUM_COLS);
    localparam int TOP = SYNC_STAGES - 1;

    typedef enum logic [1:0] {ST_CMD = 2'd0, ST_ARG1 = 2'd1, ST_ARG2 = 2'd2} state_t;
    typedef enum logic [1:0] {ARG_SKIP = 2'd0, ARG_COL = 2'd1, ARG_PAGE = 2'd2} arg_t;

    logic [SYNC_STAGES-1:0] cs_sync_r, sclk_sync_r, sdin_sync_r, dc_sync_r;
    logic                   sclk_prev_r, sclk_rise_r, sdin_d_r, dc_d_r, cs_d_r;
    logic [2:0]             bit_cnt_r;
    logic [6:0]             shift_r;
    logic                   byte_valid_r, byte_is_data_r;
    logic [7:0]             byte_data_r;
    state_t                 state_r, state_nx_s;
    arg_t                   arg_kind_r, arg_kind_nx_s;
    logic                   display_on_r, frame_done_r, proto_err_r;
    logic [7:0]             cmd_count_r, rd_data_r;
    logic [PW-1:0]          page_r, page_start_r, page_end_r;
    logic [CW-1:0]          col_r, col_start_r, col_end_r;
    logic                   wr_en_s, cs_abort_s, arg_err_s;
    logic [7:0]             fb_r [NUM_PAGES*NUM_COLS];

    assign wr_en_s    = byte_valid_r & byte_is_data_r & (state_r == ST_CMD);
    assign cs_abort_s = cs_d_r & (bit_cnt_r != 3'd0);
    assign arg_err_s  = byte_valid_r & byte_is_data_r & (state_r != ST_CMD);

    // Pin synchronisers; CS idles high so reset never looks like a selected link.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cs_sync_r   <= {SYNC_STAGES{1'b1}};
            sclk_sync_r <= {SYNC_STAGES{1'b0}};
            sdin_sync_r <= {SYNC_STAGES{1'b0}};
            dc_sync_r   <= {SYNC_STAGES{1'b0}};
        end else begin
            cs_sync_r   <= {cs_sync_r[SYNC_STAGES-2:0],   spi.CS};
            sclk_sync_r <= {sclk_sync_r[SYNC_STAGES-2:0], spi.SCLK};
            sdin_sync_r <= {sdin_sync_r[SYNC_STAGES-2:0], spi.SDIN};
            dc_sync_r   <= {dc_sync_r[SYNC_STAGES-2:0],   spi.DC};
        end
    end

    // Registered SCLK rise strobe with SDIN/DC/CS captured alongside it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sclk_prev_r <= 1'b0;
            sclk_rise_r <= 1'b0;
            sdin_d_r    <= 1'b0;
            dc_d_r      <= 1'b0;
            cs_d_r      <= 1'b1;
        end else begin
            sclk_prev_r <= sclk_sync_r[TOP];
            sclk_rise_r <= sclk_sync_r[TOP] & ~sclk_prev_r;
            sdin_d_r    <= sdin_sync_r[TOP];
            dc_d_r      <= dc_sync_r[TOP];
            cs_d_r      <= cs_sync_r[TOP];
        end
    end

    // MSB-first byte assembly; deselect discards any partial byte.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bit_cnt_r      <= 3'd0;
            shift_r        <= 7'd0;
            byte_valid_r   <= 1'b0;
            byte_data_r    <= 8'd0;
            byte_is_data_r <= 1'b0;
        end else if (cs_d_r) begin
            bit_cnt_r    <= 3'd0;
            byte_valid_r <= 1'b0;
        end else if (sclk_rise_r) begin
            shift_r   <= {shift_r[5:0], sdin_d_r};
            bit_cnt_r <= bit_cnt_r + 3'd1;
            if (bit_cnt_r == 3'd7) begin
                byte_valid_r   <= 1'b1;
                byte_data_r    <= {shift_r, sdin_d_r};
                byte_is_data_r <= dc_d_r;
            end else begin
                byte_valid_r <= 1'b0;
            end
        end else begin
            byte_valid_r <= 1'b0;
        end
    end

    // Decode state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= ST_CMD;
            arg_kind_r <= ARG_SKIP;
        end else begin
            state_r    <= state_nx_s;
            arg_kind_r <= arg_kind_nx_s;
        end
    end

    // Decode next state: multi-byte commands walk ARG1/ARG2, a data byte always returns to CMD.
    always_comb begin
        state_nx_s    = state_r;
        arg_kind_nx_s = arg_kind_r;
        if (byte_valid_r && byte_is_data_r) begin
            state_nx_s = ST_CMD;
        end else if (byte_valid_r) begin
            case (state_r)
                ST_CMD: begin
                    case (byte_data_r)
                        8'h21: begin
                            state_nx_s    = ST_ARG1;
                            arg_kind_nx_s = ARG_COL;
                        end
                        8'h22: begin
                            state_nx_s    = ST_ARG1;
                            arg_kind_nx_s = ARG_PAGE;
                        end
                        8'h20, 8'h81, 8'h8D, 8'hA8, 8'hD3, 8'hD5, 8'hD9, 8'hDA, 8'hDB: begin
                            state_nx_s    = ST_ARG1;
                            arg_kind_nx_s = ARG_SKIP;
                        end
                        default: state_nx_s = ST_CMD;
                    endcase
                end
                ST_ARG1: state_nx_s = (arg_kind_r == ARG_SKIP) ? ST_CMD : ST_ARG2;
                ST_ARG2: state_nx_s = ST_CMD;
                default: state_nx_s = ST_CMD;
            endcase
        end else begin
            state_nx_s = state_r;
        end
    end

    // Command side effects, address window and auto-increment of the write pointer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            display_on_r <= 1'b0;
            frame_done_r <= 1'b0;
            cmd_count_r  <= 8'd0;
            proto_err_r  <= 1'b0;
            page_r       <= {PW{1'b0}};
            col_r        <= {CW{1'b0}};
            page_start_r <= {PW{1'b0}};
            page_end_r   <= {PW{1'b1}};
            col_start_r  <= {CW{1'b0}};
            col_end_r    <= {CW{1'b1}};
        end else begin
            frame_done_r <= 1'b0;
            proto_err_r  <= proto_err_r | cs_abort_s | arg_err_s;
            if (byte_valid_r && !byte_is_data_r) begin
                cmd_count_r <= cmd_count_r + 8'd1;
                case (state_r)
                    ST_CMD: begin
                        case (byte_data_r) inside
                            8'hAE:          display_on_r <= 1'b0;
                            8'hAF:          display_on_r <= 1'b1;
                            [8'hB0:8'hB3]:  page_r <= byte_data_r[PW-1:0];
                            [8'h00:8'h0F]:  col_r[3:0] <= byte_data_r[3:0];
                            [8'h10:8'h17]:  col_r[CW-1:4] <= byte_data_r[CW-5:0];
                            default:        ;
                        endcase
                    end
                    ST_ARG1: begin
                        if (arg_kind_r == ARG_COL) begin
                            col_start_r <= byte_data_r[CW-1:0];
                            col_r       <= byte_data_r[CW-1:0];
                        end else if (arg_kind_r == ARG_PAGE) begin
                            page_start_r <= byte_data_r[PW-1:0];
                            page_r       <= byte_data_r[PW-1:0];
                        end else begin
                            col_r <= col_r;
                        end
                    end
                    ST_ARG2: begin
                        if (arg_kind_r == ARG_COL) begin
                            col_end_r <= byte_data_r[CW-1:0];
                        end else if (arg_kind_r == ARG_PAGE) begin
                            page_end_r <= byte_data_r[PW-1:0];
                        end else begin
                            col_r <= col_r;
                        end
                    end
                    default: ;
                endcase
            end else if (wr_en_s) begin
                if (col_r == col_end_r) begin
                    col_r <= col_start_r;
                    if (page_r == page_end_r) begin
                        page_r       <= page_start_r;
                        frame_done_r <= 1'b1;
                    end else begin
                        page_r <= page_r + 1'b1;
                    end
                end else begin
                    col_r <= col_r + 1'b1;
                end
            end else begin
                col_r <= col_r;
            end
        end
    end

    // Frame buffer write port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            fb_r[{page_r, col_r}] <= byte_data_r;
        end
    end

    // Registered read port; a same-cycle write to the same address returns the old byte.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_data_r <= 8'd0;
        end else begin
            rd_data_r <= fb_r[rd_addr];
        end
    end

    assign byte_valid   = byte_valid_r;
    assign byte_data    = byte_data_r;
    assign byte_is_data = byte_is_data_r;
    assign display_on   = display_on_r;
    assign frame_done   = frame_done_r;
    assign cmd_count    = cmd_count_r;
    assign proto_err    = proto_err_r;
    assign rd_data      = rd_data_r;
endmodule

// File: tb/tb_oled_spi_sink.sv
// Scoreboard bench for oled_spi_sink: a display-level reference model predicts every byte
// and its side effects; a monitor compares whenever the DUT reports a completed byte.
`timescale 1ns/1ps
module tb_oled_spi_sink;
    localparam int SYNC = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       byte_valid, byte_is_data, display_on, frame_done, proto_err;
    logic [7:0] byte_data, cmd_count, rd_data;
    logic [8:0] rd_addr;

    oled_spi_sink_if spi_if ();

    oled_spi_sink #(.SYNC_STAGES(SYNC), .NUM_PAGES(4), .NUM_COLS(128)) dut (
        .clk(clk), .reset(reset), .spi(spi_if.slave),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_is_data(byte_is_data),
        .display_on(display_on), .frame_done(frame_done), .cmd_count(cmd_count),
        .proto_err(proto_err), .rd_addr(rd_addr), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model (display semantics) ----------------
    typedef struct {
        logic [7:0] data;
        logic       is_data;
        logic       frame;
        logic       disp;
        logic [7:0] cnt;
        logic       err;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] mem_m [512];
    bit         known_m [512];
    int         page_m, col_m, cs_m, ce_m, ps_m, pe_m, cnt_m, fd_m;
    bit         disp_m, err_m;
    int         args_q[$];   // pending argument roles: 0 ignored, 1 col start, 2 col end, 3 page start, 4 page end

    function automatic void model_reset();
        page_m = 0; col_m = 0; cs_m = 0; ce_m = 127; ps_m = 0; pe_m = 3;
        cnt_m = 0; disp_m = 1'b0; err_m = 1'b0;
        args_q.delete();
    endfunction

    function automatic void model_byte(input logic [7:0] d, input logic dc);
        exp_t e;
        int   dd;
        int   role;
        dd = int'(d);
        e.data = d; e.is_data = dc; e.frame = 1'b0;
        if (dc) begin
            if (args_q.size() != 0) begin
                err_m = 1'b1;
                args_q.delete();
            end else begin
                mem_m[page_m*128 + col_m] = d;
                known_m[page_m*128 + col_m] = 1'b1;
                if (col_m == ce_m) begin
                    col_m = cs_m;
                    if (page_m == pe_m) begin
                        page_m = ps_m;
                        e.frame = 1'b1;
                        fd_m++;
                    end else begin
                        page_m = (page_m + 1) % 4;
                    end
                end else begin
                    col_m = (col_m + 1) % 128;
                end
            end
        end else begin
            cnt_m = (cnt_m + 1) % 256;
            if (args_q.size() != 0) begin
                role = args_q.pop_front();
                case (role)
                    1: begin cs_m = dd % 128; col_m = cs_m; end
                    2: ce_m = dd % 128;
                    3: begin ps_m = dd % 4; page_m = ps_m; end
                    4: pe_m = dd % 4;
                    default: ;
                endcase
            end else if (dd == 'hAE) disp_m = 1'b0;
            else if (dd == 'hAF) disp_m = 1'b1;
            else if (dd >= 'hB0 && dd <= 'hB3) page_m = dd - 'hB0;
            else if (dd <= 'h0F) col_m = (col_m / 16) * 16 + dd;
            else if (dd <= 'h17) col_m = (dd - 'h10) * 16 + col_m % 16;
            else if (dd == 'h21) begin args_q.push_back(1); args_q.push_back(2); end
            else if (dd == 'h22) begin args_q.push_back(3); args_q.push_back(4); end
            else if (d inside {8'h20, 8'h81, 8'h8D, 8'hA8, 8'hD3, 8'hD5, 8'hD9, 8'hDA, 8'hDB})
                args_q.push_back(0);
        end
        e.disp = disp_m; e.cnt = 8'(cnt_m); e.err = err_m;
        exp_q.push_back(e);
    endfunction

    // ---------------- monitor ----------------
    int fd_cnt = 0;
    always @(negedge clk) if (frame_done === 1'b1) fd_cnt <= fd_cnt + 1;

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset === 1'b1 && byte_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    tests_run++;
                    tests_failed++;
                    $display("FAIL unexpected_byte: got byte 0x%0h, expected none", byte_data);
                end else begin
                    e = exp_q.pop_front();
                    check("byte_data", byte_data, e.data);
                    check("byte_is_data", byte_is_data, e.is_data);
                    @(negedge clk);
                    check("frame_done", frame_done, e.frame);
                    check("display_on", display_on, e.disp);
                    check("cmd_count", cmd_count, e.cnt);
                    check("proto_err", proto_err, e.err);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic spi_bits(input logic [7:0] d, input int nbits, input logic dc, output int lat);
        lat = 0;
        spi_if.DC = dc;
        for (int i = 0; i < nbits; i++) begin
            spi_if.SDIN = d[7-i];
            repeat (4) @(posedge clk);
            #1 spi_if.SCLK = 1'b1;
            if (i == 7) begin
                for (int k = 1; k <= 6; k++) begin
                    @(posedge clk);
                    @(negedge clk);
                    if (byte_valid === 1'b1 && lat == 0) lat = k;
                end
                @(posedge clk);
                #1;
            end else begin
                repeat (4) @(posedge clk);
                #1;
            end
            spi_if.SCLK = 1'b0;
        end
    endtask

    task automatic send(input logic [7:0] d, input logic dc);
        int lat;
        model_byte(d, dc);
        spi_bits(d, 8, dc, lat);
    endtask

    task automatic rd_chk(input string nm, input logic [8:0] a, input logic [7:0] exp);
        @(negedge clk);
        rd_addr = a;
        @(negedge clk);
        check(nm, rd_data, exp);
    endtask

    initial begin : stim
        int         lat;
        logic [7:0] va, vb, vc, v;
        logic [7:0] misc [5];
        misc = '{8'hAE, 8'hAF, 8'h81, 8'h20, 8'hD5};
        for (int i = 0; i < 512; i++) known_m[i] = 1'b0;
        fd_m = 0;
        model_reset();
        reset = 1'b0;
        spi_if.CS = 1'b1; spi_if.SDIN = 1'b0; spi_if.SCLK = 1'b0; spi_if.DC = 1'b0;
        rd_addr = 9'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_byte_valid", byte_valid, 1'b0);
        check("rst_byte_data", byte_data, 8'd0);
        check("rst_display_on", display_on, 1'b0);
        check("rst_cmd_count", cmd_count, 8'd0);
        check("rst_proto_err", proto_err, 1'b0);
        check("rst_rd_data", rd_data, 8'd0);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 spi_if.CS = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        // Single command byte with latency measurement
        model_byte(8'hAF, 1'b0);
        spi_bits(8'hAF, 8, 1'b0, lat);
        check("byte_latency", lat, SYNC + 2);

        // Full frame over the whole window
        send(8'h21, 1'b0); send(8'h00, 1'b0); send(8'h7F, 1'b0);
        send(8'h22, 1'b0); send(8'h00, 1'b0); send(8'h03, 1'b0);
        for (int i = 0; i < 512; i++) send(8'(i), 1'b1);
        for (int i = 0; i < 512; i += 37) rd_chk("full_frame_buf", 9'(i), 8'(i));
        rd_chk("full_frame_last", 9'd511, 8'hFF);
        send(8'hC3, 1'b1);
        repeat (4) @(posedge clk);
        rd_chk("wrapped_to_origin", 9'd0, 8'hC3);

        // Small window wrap
        va = 8'($urandom); vb = 8'($urandom); vc = 8'($urandom);
        send(8'h21, 1'b0); send(8'h10, 1'b0); send(8'h11, 1'b0);
        send(8'h22, 1'b0); send(8'h02, 1'b0); send(8'h02, 1'b0);
        send(va, 1'b1); send(vb, 1'b1); send(vc, 1'b1);
        repeat (4) @(posedge clk);
        rd_chk("win_wrap_110", 9'h110, vc);
        rd_chk("win_wrap_111", 9'h111, vb);

        // Page-mode addressing
        send(8'hB1, 1'b0); send(8'h05, 1'b0); send(8'h13, 1'b0); send(8'h5A, 1'b1);
        repeat (4) @(posedge clk);
        rd_chk("page_mode_write", {2'd1, 7'd53}, 8'h5A);

        // CS released after five bits
        spi_bits(8'h96, 5, 1'b0, lat);
        repeat (4) @(posedge clk);
        #1 spi_if.CS = 1'b1;
        err_m = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("cs_abort_proto_err", proto_err, 1'b1);
        spi_if.CS = 1'b0;
        repeat (6) @(posedge clk);
        #1;

        // Data byte where an argument is expected; pointer back at {1,53}
        send(8'hB1, 1'b0); send(8'h05, 1'b0); send(8'h13, 1'b0);
        send(8'h81, 1'b0); send(8'hEE, 1'b1); send(8'hAE, 1'b0);
        repeat (4) @(posedge clk);
        rd_chk("arg_data_no_write", {2'd1, 7'd53}, 8'h5A);

        // Randomised command/data mix
        for (int n = 0; n < 120; n++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4: send(8'($urandom), 1'b1);
                5: send(8'(8'hB0 + 8'($urandom_range(0, 3))), 1'b0);
                6: send(8'($urandom_range(0, 23)), 1'b0);
                7: begin send(8'h21, 1'b0); send(8'($urandom), 1'b0); send(8'($urandom), 1'b0); end
                8: begin send(8'h22, 1'b0); send(8'($urandom), 1'b0); send(8'($urandom), 1'b0); end
                default: send(misc[$urandom_range(0, 4)], 1'b0);
            endcase
        end

        // Asynchronous reset in the middle of a byte
        send(8'hAF, 1'b0);
        spi_bits(8'hA5, 4, 1'b0, lat);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        check("mid_rst_byte_valid", byte_valid, 1'b0);
        check("mid_rst_byte_data", byte_data, 8'd0);
        check("mid_rst_is_data", byte_is_data, 1'b0);
        check("mid_rst_display_on", display_on, 1'b0);
        check("mid_rst_frame_done", frame_done, 1'b0);
        check("mid_rst_cmd_count", cmd_count, 8'd0);
        check("mid_rst_proto_err", proto_err, 1'b0);
        check("mid_rst_rd_data", rd_data, 8'd0);
        model_reset();
        spi_if.SCLK = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        send(8'hAF, 1'b0);
        send(8'h42, 1'b1);

        // Drain scoreboard and read back every byte the model knows about
        for (int k = 0; k < 2000 && exp_q.size() != 0; k++) @(posedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        repeat (4) @(posedge clk);
        for (int i = 0; i < 512; i++) begin
            if (known_m[i]) begin
                v = mem_m[i];
                rd_chk("buffer_readback", 9'(i), v);
            end
        end
        check("frame_done_pulses", fd_cnt, fd_m);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/oled_spi_sink.md
Name: oled_spi_sink

Overview:
- Responder end of the OLED SPI link: accepts the CS/SDIN/SCLK/DC stream an OLED controller emits and decodes it as an SSD1306-subset panel would.
- Assembles bytes and separates commands from data by DC.
- Tracks page/column addressing and writes data bytes into a 4-page x 128-column frame buffer, readable by the bench or an on-chip checker.
- Sits beside the OLED pins as a display model / link snooper; runs on the system clock with SCLK oversampled.

Parameters:
- SYNC_STAGES, 2, synchroniser depth on CS, SCLK, SDIN, DC; legal values 2..3.
- NUM_PAGES, 4, display pages; 8-pixel rows each; page index is 2 bits.
- NUM_COLS, 128, columns per page; column index is 7 bits.

Ports:
- clk, input, 1, system clock.
- reset, input, 1, asynchronous, active-low (0 = reset).
- CS, input, 1, chip select from controller, active-low.
- SDIN, input, 1, serial data, MSB first.
- SCLK, input, 1, serial clock; data sampled on rising edge.
- DC, input, 1, 0 = command byte, 1 = data byte; sampled with the 8th bit.
- byte_valid, output, 1, one-cycle pulse per completed byte.
- byte_data, output, 8, last completed byte.
- byte_is_data, output, 1, DC value latched with byte_data.
- display_on, output, 1, set by 0xAF, cleared by 0xAE.
- frame_done, output, 1, one-cycle pulse when the address window wraps.
- cmd_count, output, 8, count of command bytes received, wraps at 255.
- proto_err, output, 1, sticky protocol-error flag.
- rd_addr, input, 9, frame-buffer read address {page[1:0], col[6:0]}.
- rd_data, output, 8, frame-buffer byte; 1-cycle registered read latency.

Behaviour:
- Reset (reset=0, async) clears:
  - outputs: byte_valid, byte_data, byte_is_data, display_on, frame_done, cmd_count, proto_err, rd_data all 0.
  - internal: bit counter 0; page=0, col=0; window col 0..127, page 0..3; FSM=CMD.
  - Frame buffer contents are not cleared.
- Synchronisation and sampling:
  - All four pins pass through SYNC_STAGES flops; SCLK edge is detected on the synchronised signal.
  - SCLK high and low phases must each be >= 4 clk periods.
  - byte_valid asserts exactly SYNC_STAGES+2 clk cycles after the 8th SCLK rising pin edge.
- Bit assembly:
  - While synchronised CS=0, each SCLK rise shifts SDIN in MSB-first and increments the bit counter.
  - On the 8th bit: byte_data, byte_is_data and a byte_valid pulse update; counter returns to 0.
  - CS high clears the counter. If the counter was nonzero, the partial byte is dropped and proto_err is set.
- Decode FSM: CMD, ARG1, ARG2.
  - In CMD, on a command byte, cmd_count increments and:
    - 0xAE / 0xAF: display_on <= 0 / 1.
    - 0xB0-0xB3: page <= byte[1:0].
    - 0x00-0x0F: col[3:0] <= byte[3:0].
    - 0x10-0x17: col[6:4] <= byte[2:0].
    - 0x21: column window -> ARG1 (col_start, low 7 bits) -> ARG2 (col_end); col <= col_start on ARG1.
    - 0x22: page window -> ARG1 (page_start, low 2 bits) -> ARG2 (page_end); page <= page_start on ARG1.
    - 0x20, 0x81, 0x8D, 0xA8, 0xD3, 0xD5, 0xD9, 0xDA, 0xDB: take one ignored argument via ARG1, then CMD.
    - All others: no effect.
  - Argument bytes also increment cmd_count.
  - A data byte (DC=1) while in ARG1/ARG2: byte is dropped, proto_err is set, FSM returns to CMD.
- Data write (DC=1 in CMD):
  - Buffer[{page,col}] <= byte.
  - If col == col_end: col <= col_start; then if page == page_end, page <= page_start and frame_done pulses in the cycle after byte_valid; else page <= page+1 (mod 4).
  - Otherwise col <= col+1 (mod 128).
  - If start > end, the index increments modulo its range until it equals end.
- Read port: rd_data is valid the cycle after rd_addr. When a read and a write hit the same address in the same cycle, the read returns the old value.
- Reset mid-byte or mid-argument: immediate return to the reset state; no byte_valid is emitted.

Test Plan:
- Byte timing: CS=0, DC=0, shift 0xAF -> one byte_valid at SYNC_STAGES+2 cycles after 8th edge, byte_data=0xAF, byte_is_data=0, display_on=1, cmd_count=1.
- Full frame: commands 0x21,0x00,0x7F,0x22,0x00,0x03, then 512 data bytes i[7:0] -> buffer[i]=i[7:0], exactly one frame_done after byte 512, page/col back to 0/0.
- Window wrap: 0x21,0x10,0x11 and 0x22,0x02,0x02, then 3 data bytes A,B,C -> buffer[0x110]=A, [0x111]=B, then [0x110]=C, frame_done after B.
- Page-mode addressing: 0xB1, 0x05, 0x13, then data 0x5A -> buffer[{2'd1,7'd53}]=0x5A.
- Errors: CS high after 5 bits -> no byte_valid, proto_err=1. Separately, 0x81 followed by a DC=1 byte -> proto_err=1, buffer unchanged, next 0xAE decoded.
- Async reset asserted mid-byte -> all outputs 0 immediately. A fresh byte after release decodes correctly.
